// File: rtl/invader_fleet.sv
// Invader formation owner: once per frame scans every slot against the laser,
// kills at most one invader, then advances the march or respawns the wave.
module invader_fleet #(
    parameter int ROWS            = 4,
    parameter int COLS            = 8,
    parameter int INV_W           = 16,
    parameter int INV_H           = 16,
    parameter int SPACING_X       = 32,
    parameter int SPACING_Y       = 24,
    parameter int START_X         = 64,
    parameter int START_Y         = 48,
    parameter int STEP_X          = 2,
    parameter int STEP_DOWN       = 8,
    parameter int X_MIN           = 16,
    parameter int X_MAX           = 624,
    parameter int BOTTOM_Y        = 400,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 frame,
    input  logic                 laser_active,
    input  logic [9:0]           laser_x,
    input  logic [9:0]           laser_y,
    output logic                 invader_collision,
    output logic                 wave_cleared,
    output logic                 reached_bottom,
    output logic [9:0]           fleet_x,
    output logic [9:0]           fleet_y,
    output logic [ROWS*COLS-1:0] alive
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [10:0] SX11   = 11'(SPACING_X);
    localparam logic [10:0] SY11   = 11'(SPACING_Y);
    localparam logic [10:0] W11    = 11'(INV_W);
    localparam logic [10:0] H11    = 11'(INV_H);
    localparam logic [10:0] STX11  = 11'(STEP_X);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] BOT11  = 11'(BOTTOM_Y);

    typedef enum logic [1:0] {IDLE, SCAN, MOVE} state_t;
    state_t state_reg, state_next;

    logic [N-1:0]    alive_reg;
    logic [9:0]      fx_reg, fy_reg, lx_reg, ly_reg;
    logic            la_reg, dir_left_reg, coll_reg, rb_reg;
    logic [RW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic [SW-1:0]   step_reg;
    logic [IW-1:0]   idx;
    logic [10:0]     fx11, fy11, lx11, ly11, bx, by;
    logic            hit, last, scan_en, move_en, edge_hit, bottom_now;
    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;
    logic [CW-1:0]   l_col, r_col;
    logic [RW-1:0]   b_row;

    assign fx11 = {1'b0, fx_reg};
    assign fy11 = {1'b0, fy_reg};
    assign lx11 = {1'b0, lx_reg};
    assign ly11 = {1'b0, ly_reg};
    assign idx  = IW'(row_reg) * IW'(COLS) + IW'(col_reg);
    assign last = (row_reg == RW'(ROWS - 1)) && (col_reg == CW'(COLS - 1));

    always_comb begin
        bx  = fx11 + 11'(col_reg) * SX11;
        by  = fy11 + 11'(row_reg) * SY11;
        hit = la_reg && alive_reg[idx] && (lx11 >= bx) && (lx11 < bx + W11)
              && (ly11 >= by) && (ly11 < by + H11);
    end

    // Occupancy per column/row drives the march extents and the invasion line.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic any;
            always_comb begin
                any = 1'b0;
                for (int r = 0; r < ROWS; r++) any = any | alive_reg[r*COLS+gi];
            end
            assign col_alive[gi] = any;
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_alive[gi] = |alive_reg[gi*COLS +: COLS];
        end
    endgenerate

    always_comb begin
        l_col = '0;
        r_col = '0;
        b_row = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_alive[c]) l_col = CW'(c);
        for (int c = 0; c < COLS; c++)      if (col_alive[c]) r_col = CW'(c);
        for (int r = 0; r < ROWS; r++)      if (row_alive[r]) b_row = RW'(r);
    end

    always_comb begin
        if (dir_left_reg) edge_hit = (fx11 + 11'(l_col) * SX11) < (XMIN11 + STX11);
        else              edge_hit = (fx11 + 11'(r_col) * SX11 + W11 + STX11) > XMAX11;
        bottom_now = (|alive_reg) && ((fy11 + 11'(b_row) * SY11 + H11) >= BOT11);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame) state_next = SCAN;
            SCAN:    if (hit || last) state_next = MOVE;
            MOVE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scan_en      = 1'b0;
        move_en      = 1'b0;
        wave_cleared = 1'b0;
        case (state_reg)
            SCAN: scan_en = 1'b1;
            MOVE: begin
                move_en      = 1'b1;
                wave_cleared = ~|alive_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            alive_reg    <= '1;
            fx_reg       <= 10'(START_X);
            fy_reg       <= 10'(START_Y);
            dir_left_reg <= 1'b0;
            step_reg     <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            la_reg       <= 1'b0;
            lx_reg       <= '0;
            ly_reg       <= '0;
            coll_reg     <= 1'b0;
            rb_reg       <= 1'b0;
        end else begin
            coll_reg <= scan_en && hit;
            rb_reg   <= rb_reg | bottom_now;
            if (state_reg == IDLE && frame) begin
                la_reg  <= laser_active;
                lx_reg  <= laser_x;
                ly_reg  <= laser_y;
                row_reg <= '0;
                col_reg <= '0;
            end
            if (scan_en) begin
                if (hit) begin
                    alive_reg[idx] <= 1'b0;
                end else if (col_reg == CW'(COLS - 1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RW'(1);
                end else begin
                    col_reg <= col_reg + CW'(1);
                end
            end
            if (move_en) begin
                if (~|alive_reg) begin
                    alive_reg    <= '1;
                    fx_reg       <= 10'(START_X);
                    fy_reg       <= 10'(START_Y);
                    dir_left_reg <= 1'b0;
                    step_reg     <= '0;
                end else if (!rb_reg) begin
                    if (step_reg == SW'(FRAMES_PER_STEP - 1)) begin
                        step_reg <= '0;
                        if (edge_hit) begin
                            fy_reg       <= fy_reg + 10'(STEP_DOWN);
                            dir_left_reg <= !dir_left_reg;
                        end else if (dir_left_reg) begin
                            fx_reg <= fx_reg - 10'(STEP_X);
                        end else begin
                            fx_reg <= fx_reg + 10'(STEP_X);
                        end
                    end else begin
                        step_reg <= step_reg + SW'(1);
                    end
                end
            end
        end
    end

    assign invader_collision = coll_reg;
    assign reached_bottom    = rb_reg;
    assign fleet_x           = fx_reg;
    assign fleet_y           = fy_reg;
    assign alive             = alive_reg;
endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: table of per-frame vectors through a scoreboard queue,
// plus hand-written edge, wave-clear, mid-scan reset and invasion sequences.
module tb_invader_fleet;
    logic        clk = 1'b0;
    logic        arst, frame, laser_active;
    logic [9:0]  laser_x, laser_y;
    logic        invader_collision, wave_cleared, reached_bottom;
    logic [9:0]  fleet_x, fleet_y;
    logic [31:0] alive;

    logic        frame2, laser_active2;
    logic [9:0]  laser_x2, laser_y2;
    logic        invader_collision2, wave_cleared2, reached_bottom2;
    logic [9:0]  fleet_x2, fleet_y2;
    logic [31:0] alive2;

    always #5 clk = ~clk;

    invader_fleet dut (
        .clk(clk), .arst(arst), .frame(frame), .laser_active(laser_active),
        .laser_x(laser_x), .laser_y(laser_y), .invader_collision(invader_collision),
        .wave_cleared(wave_cleared), .reached_bottom(reached_bottom),
        .fleet_x(fleet_x), .fleet_y(fleet_y), .alive(alive)
    );

    // Narrow playfield and low invasion line so the fleet drops on every frame.
    invader_fleet #(.FRAMES_PER_STEP(1), .X_MIN(63), .X_MAX(305), .BOTTOM_Y(152)) dut2 (
        .clk(clk), .arst(arst), .frame(frame2), .laser_active(laser_active2),
        .laser_x(laser_x2), .laser_y(laser_y2), .invader_collision(invader_collision2),
        .wave_cleared(wave_cleared2), .reached_bottom(reached_bottom2),
        .fleet_x(fleet_x2), .fleet_y(fleet_y2), .alive(alive2)
    );

    typedef struct {
        bit          la;
        int          lx;
        int          ly;
        int          hit_j;
        int          fx;
        int          fy;
        logic [31:0] alv;
    } vec_t;

    vec_t vecs[16];
    vec_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Caller sits on a negedge; j counts cycles after the frame cycle.
    task automatic run_frame(input bit la, input int lx, input int ly,
                             output int hit_j, output int hits, output int wave_j, output int waves);
        laser_active = la;
        laser_x      = lx[9:0];
        laser_y      = ly[9:0];
        frame        = 1'b1;
        hit_j = 0; hits = 0; wave_j = 0; waves = 0;
        for (int j = 1; j <= 36; j++) begin
            @(negedge clk);
            if (j == 1) frame = 1'b0;
            if (invader_collision) begin
                hits++;
                if (hit_j == 0) hit_j = j;
            end
            if (wave_cleared) begin
                waves++;
                if (wave_j == 0) wave_j = j;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic bulk(input int n, input string name);
        int hj, h, wj, w, sum;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            run_frame(1'b0, 0, 0, hj, h, wj, w);
            sum += h + w;
        end
        check(name, sum, 0);
    endtask

    task automatic edge_seq(input string tag, input int fx_edge);
        int hj, h, wj, w;
        for (int i = 0; i < 4; i++) run_frame(1'b0, 0, 0, hj, h, wj, w);
        check({tag, "_drop_fy"}, fleet_y, 56);
        check({tag, "_drop_fx"}, fleet_x, fx_edge);
        for (int i = 0; i < 4; i++) run_frame(1'b0, 0, 0, hj, h, wj, w);
        check({tag, "_left_fx"}, fleet_x, fx_edge - 2);
        check({tag, "_left_fy"}, fleet_y, 56);
    endtask

    task automatic frame2_pulse();
        frame2 = 1'b1;
        @(negedge clk);
        frame2 = 1'b0;
        repeat (38) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hj, h, wj, w, kills_ok, waves_tot, fx_m;
        vec_t e;

        vecs[0]  = '{1'b0, 0,   0,  0, 64, 48, 32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, 0,   0,  0, 64, 48, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b0, 0,   0,  0, 64, 48, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b0, 0,   0,  0, 66, 48, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b0, 0,   0,  0, 66, 48, 32'hFFFF_FFFF};
        vecs[5]  = '{1'b0, 0,   0,  0, 66, 48, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 0,   0,  0, 66, 48, 32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, 0,   0,  0, 68, 48, 32'hFFFF_FFFF};
        vecs[8]  = '{1'b1, 132, 76, 12, 68, 48, 32'hFFFF_FBFF};
        vecs[9]  = '{1'b1, 132, 76, 0,  68, 48, 32'hFFFF_FBFF};
        vecs[10] = '{1'b1, 0,   0,  0,  68, 48, 32'hFFFF_FBFF};
        vecs[11] = '{1'b0, 0,   0,  0,  70, 48, 32'hFFFF_FBFF};
        vecs[12] = '{1'b1, 86,  48, 0,  70, 48, 32'hFFFF_FBFF};
        vecs[13] = '{1'b1, 70,  63, 2,  70, 48, 32'hFFFF_FBFE};
        vecs[14] = '{1'b1, 117, 64, 0,  70, 48, 32'hFFFF_FBFE};
        vecs[15] = '{1'b1, 117, 63, 3,  72, 48, 32'hFFFF_FBFC};

        arst = 1'b1; frame = 1'b0; laser_active = 1'b0; laser_x = '0; laser_y = '0;
        frame2 = 1'b0; laser_active2 = 1'b0; laser_x2 = '0; laser_y2 = '0;
        repeat (3) @(negedge clk);
        arst = 1'b0;

        check("reset_fleet_x", fleet_x, 64);
        check("reset_fleet_y", fleet_y, 48);
        check("reset_alive", alive, 32'hFFFF_FFFF);
        check("reset_collision", invader_collision, 0);
        check("reset_wave", wave_cleared, 0);
        check("reset_bottom", reached_bottom, 0);

        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(vecs[i]);
            run_frame(vecs[i].la, vecs[i].lx, vecs[i].ly, hj, h, wj, w);
            e = exp_q.pop_front();
            $display("frame %0d laser=%0b (%0d,%0d) hit_j=%0d fleet=(%0d,%0d) alive=%h",
                     i, e.la, e.lx, e.ly, hj, fleet_x, fleet_y, alive);
            check($sformatf("vec%0d_hit_cycle", i), hj, e.hit_j);
            check($sformatf("vec%0d_hit_count", i), h, (e.hit_j != 0) ? 1 : 0);
            check($sformatf("vec%0d_fleet_x", i), fleet_x, e.fx);
            check($sformatf("vec%0d_fleet_y", i), fleet_y, e.fy);
            check($sformatf("vec%0d_alive", i), alive, e.alv);
            check($sformatf("vec%0d_wave", i), w, 0);
        end

        // Right edge with the full width: 156 steps from 72 lands on 384.
        bulk(624, "march_to_384_quiet");
        check("edge384_fx", fleet_x, 384);
        check("edge384_fy", fleet_y, 48);
        edge_seq("edge384", 384);

        // Column 7 gone: the right extent shrinks by one pitch.
        do_reset();
        check("reset2_fleet_y", fleet_y, 48);
        for (int r = 0; r < 4; r++) begin
            run_frame(1'b1, 296, 56 + 24 * r, hj, h, wj, w);
            $display("col7 kill row %0d hit_j=%0d", r, hj);
            check($sformatf("col7_r%0d_hit_cycle", r), hj, 9 + 8 * r);
        end
        check("col7_alive", alive, 32'h7F7F_7F7F);
        check("col7_fx_after4", fleet_x, 66);
        bulk(700, "march_to_416_quiet");
        check("edge416_fx", fleet_x, 416);
        edge_seq("edge416", 416);

        // Wave clear: kill row-major while tracking the march independently.
        do_reset();
        kills_ok = 0;
        waves_tot = 0;
        for (int k = 0; k < 32; k++) begin
            fx_m = 64 + 2 * (k / 4);
            run_frame(1'b1, fx_m + (k % 8) * 32 + 8, 48 + (k / 8) * 24 + 8, hj, h, wj, w);
            $display("wave kill idx %0d hit_j=%0d wave_j=%0d", k, hj, wj);
            if (hj == 2 + k && h == 1) kills_ok++;
            waves_tot += w;
            if (k == 31) check("wave_pulse_cycle", wj, 33);
        end
        check("wave_all_kills", kills_ok, 32);
        check("wave_pulse_count", waves_tot, 1);
        check("wave_alive_reload", alive, 32'hFFFF_FFFF);
        check("wave_fleet_x", fleet_x, 64);
        check("wave_fleet_y", fleet_y, 48);

        // Mid-scan reset: aim at idx 20 but pull arst before the scan reaches it.
        run_frame(1'b1, 72, 56, hj, h, wj, w);
        check("pre_reset_alive", alive, 32'hFFFF_FFFE);
        laser_active = 1'b1; laser_x = 10'd200; laser_y = 10'd104;
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
        repeat (4) @(negedge clk);
        arst = 1'b1;
        #1;
        check("midscan_alive", alive, 32'hFFFF_FFFF);
        check("midscan_collision", invader_collision, 0);
        check("midscan_fleet_x", fleet_x, 64);
        @(negedge clk);
        arst = 1'b0;
        h = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            h += int'(invader_collision) + int'(wave_cleared);
        end
        check("midscan_no_pulse", h, 0);
        run_frame(1'b1, 200, 104, hj, h, wj, w);
        $display("post-reset frame hit_j=%0d alive=%h", hj, alive);
        check("post_reset_hit_cycle", hj, 22);
        check("post_reset_alive", alive, 32'hFFEF_FFFF);

        // Invasion on the narrow instance: two drops bring row 3 to the line.
        check("inv_reset_bottom", reached_bottom2, 0);
        frame2_pulse();
        $display("invasion frame 1 fleet=(%0d,%0d) bottom=%0b", fleet_x2, fleet_y2, reached_bottom2);
        check("inv_f1_fy", fleet_y2, 56);
        check("inv_f1_bottom", reached_bottom2, 0);
        frame2_pulse();
        $display("invasion frame 2 fleet=(%0d,%0d) bottom=%0b", fleet_x2, fleet_y2, reached_bottom2);
        check("inv_f2_fy", fleet_y2, 64);
        check("inv_f2_bottom", reached_bottom2, 1);
        frame2_pulse();
        $display("invasion frame 3 fleet=(%0d,%0d) bottom=%0b", fleet_x2, fleet_y2, reached_bottom2);
        check("inv_frozen_fx", fleet_x2, 64);
        check("inv_frozen_fy", fleet_y2, 64);
        check("inv_sticky", reached_bottom2, 1);
        do_reset();
        check("inv_cleared_by_reset", reached_bottom2, 0);
        check("inv_reset_fy", fleet_y2, 48);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/invader_fleet.md
# invader_fleet

Owns the invader formation for the game: alive mask, fleet origin, march direction and step timing. Once per `frame` it scans the formation against the player laser and pulses `invader_collision`, which drives `score_logic` and `laser`. It then advances the march. It feeds the VGA stage with the fleet position and alive mask for drawing.

## Interface
- `ROWS`, 4, formation rows (row 0 on top)
- `COLS`, 8, formation columns (col 0 on left)
- `INV_W`, 16, invader width in pixels
- `INV_H`, 16, invader height in pixels
- `SPACING_X`, 32, column pitch in pixels
- `SPACING_Y`, 24, row pitch in pixels
- `START_X`, 64, reset/respawn fleet_x
- `START_Y`, 48, reset/respawn fleet_y
- `STEP_X`, 2, horizontal step in pixels
- `STEP_DOWN`, 8, drop in pixels at an edge
- `X_MIN`, 16, left bound (inclusive)
- `X_MAX`, 624, right bound (exclusive edge)
- `BOTTOM_Y`, 400, invasion line
- `FRAMES_PER_STEP`, 4, frames between march steps

Ports:
- `clk` in 1: system clock
- `arst` in 1: asynchronous, active-high reset
- `frame` in 1: one-cycle pulse per video frame
- `laser_active` in 1: laser in flight
- `laser_x`, `laser_y` in 10 each: laser tip coordinate
- `invader_collision` out 1: one-cycle hit pulse
- `wave_cleared` out 1: one-cycle pulse when the last invader dies
- `reached_bottom` out 1: sticky invasion flag
- `fleet_x`, `fleet_y` out 10 each: top-left of invader (0,0) slot
- `alive` out ROWS*COLS: bit index = row*COLS+col

## Operation
- **Invader box.** Invader i occupies x in [fleet_x+col*SPACING_X, +INV_W) and y in [fleet_y+row*SPACING_Y, +INV_H).
- **FSM states:** IDLE, SCAN, MOVE.
- **IDLE:**
  - On `frame`, latch `laser_active`, `laser_x` and `laser_y`, set idx=0, go to SCAN.
  - A `frame` seen in SCAN or MOVE is ignored.
- **SCAN:** one invader per cycle, idx 0 to N-1 (N=ROWS*COLS).
  - Hit condition: latched laser active, alive[idx]=1, and the laser point is inside the box.
  - On a hit: clear alive[idx], assert `invader_collision` next cycle, end the scan (at most one kill per frame) and go to MOVE.
  - If idx=N-1 and there is no hit, go to MOVE.
- **MOVE, evaluated in order:**
  1. If alive==0: reload alive to all ones, fleet to START, direction to right, step counter to 0. Pulse `wave_cleared` in the same cycle.
  2. Else if `reached_bottom`: no movement.
  3. Else increment the step counter. When it reaches FRAMES_PER_STEP-1, reset it to 0 and march.
- **March extents.** Compute leftmost alive column L and rightmost alive column R from the post-scan alive mask.
  - Moving right: if fleet_x+R*SPACING_X+INV_W+STEP_X > X_MAX, then fleet_y += STEP_DOWN, direction becomes left, fleet_x unchanged. Otherwise fleet_x += STEP_X.
  - Moving left: if fleet_x+L*SPACING_X < X_MIN+STEP_X, then drop and reverse the same way. Otherwise fleet_x -= STEP_X.
- **reached_bottom.**
  - Set when the bottom of the lowest alive row, fleet_y+r*SPACING_Y+INV_H, is >= BOTTOM_Y. It is evaluated on the registered fleet_y.
  - Sticky until `arst`; a wave clear does not clear it.
- **Arithmetic.** All coordinate arithmetic is 11-bit unsigned. Parameters guarantee no underflow.

## Timing
- **Reset values:**
  - fleet_x=START_X, fleet_y=START_Y
  - alive all ones, direction right
  - step counter 0, idx 0, state IDLE
  - all pulses and `reached_bottom` 0
- **Scan timing.** For `frame` at cycle t, invader idx is checked in cycle t+1+idx.
- **Hit on idx k:** `invader_collision` high in cycle t+2+k only, and `alive` updates in the same cycle.
- **No hit:** MOVE in cycle t+1+N, and position/`wave_cleared` are visible in cycle t+2+N.
- **With a hit on idx k:** MOVE in cycle t+2+k.
- **Return to IDLE.** The FSM is back in IDLE the cycle after MOVE, well within one frame.
- **Mid-operation reset.** `arst` asserted mid-scan or mid-move returns everything to reset values immediately, with no pulse emitted.

## Test plan
- **Reset:** assert `arst` -> fleet_x=64, fleet_y=48, alive=32'hFFFFFFFF, all pulses 0.
- **March:** 4 frames with laser inactive -> fleet_x 66 after the 4th MOVE, then 68 after the 8th; fleet_y stays 48.
- **Hit:**
  - Laser at (132,76), inside row1/col2 (idx 10), with `frame` at t -> `invader_collision` high exactly in cycle t+12 and alive[10]=0.
  - A second frame with the same laser -> no pulse.
- **Right edge:**
  - March to fleet_x=384 (right edge 624). Next step -> fleet_y=56, direction left, fleet_x=384.
  - Repeat after killing column 7 -> the drop happens at fleet_x=416.
- **Wave clear:** kill all 32 invaders -> `wave_cleared` pulses once in the final MOVE; next cycle alive is all ones and fleet is at (64,48).
- **Invasion and reset mid-scan:**
  - Force drops until fleet_y+3*24+16 >= 400 -> `reached_bottom`=1 and fleet_x frozen.
  - Assert `arst` during a SCAN -> reset values and no pulse.
